// File: rtl/hand_scorer_pkg.sv
// Shared phase/result encodings and scoring defaults for the blackjack hand scorer.
package hand_scorer_pkg;

  localparam int DEALER_STAND_DEF = 17;
  localparam int TARGET_DEF       = 21;

  typedef enum logic [2:0] {
    PH_IDLE    = 3'd0,
    PH_DEAL_P1 = 3'd1,
    PH_DEAL_D1 = 3'd2,
    PH_DEAL_P2 = 3'd3,
    PH_DEAL_D2 = 3'd4,
    PH_PLAYER  = 3'd5,
    PH_DEALER  = 3'd6,
    PH_DONE    = 3'd7
  } phase_e;

  typedef enum logic [1:0] {
    RES_NONE   = 2'b00,
    RES_PLAYER = 2'b01,
    RES_DEALER = 2'b10,
    RES_PUSH   = 2'b11
  } result_e;

  // Final outcome once the dealer has stopped; the player is known not to be bust here.
  function automatic result_e settle(input logic [4:0] p, input logic [4:0] d, input logic d_bust);
    result_e r;
    if (d_bust || p > d) r = RES_PLAYER;
    else if (d > p)      r = RES_DEALER;
    else                 r = RES_PUSH;
    return r;
  endfunction

endpackage

// File: rtl/hand_scorer_accum.sv
// One hand: hard sum plus ace flag, producing the soft-adjusted total and bust flag.
module hand_accum
  import hand_scorer_pkg::*;
#(
  parameter int TARGET = TARGET_DEF
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clear_i,
  input  logic       add_i,
  input  logic [3:0] card_i,
  output logic [4:0] total_o,
  output logic       bust_o
);

  // An ace counts 11 only while that keeps the hand at or below TARGET.
  localparam logic [4:0] SOFT_MAX = 5'(TARGET - 10);
  localparam logic [4:0] TGT      = 5'(TARGET);

  logic [4:0] hard_q, hard_d;
  logic       ace_q, ace_d;
  logic [5:0] sum;

  // Next hard sum / ace flag; the sum saturates at 31 so it can never wrap.
  always_comb begin
    sum    = {1'b0, hard_q} + {2'b00, card_i};
    hard_d = hard_q;
    ace_d  = ace_q;
    if (clear_i) begin
      hard_d = '0;
      ace_d  = 1'b0;
    end else if (add_i) begin
      hard_d = sum[5] ? 5'd31 : sum[4:0];
      ace_d  = ace_q | (card_i == 4'd1);
    end
  end

  // Hand state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hard_q <= '0;
      ace_q  <= 1'b0;
    end else begin
      hard_q <= hard_d;
      ace_q  <= ace_d;
    end
  end

  assign total_o = (ace_q && hard_q <= SOFT_MAX) ? hard_q + 5'd10 : hard_q;
  assign bust_o  = total_o > TGT;

endmodule

// File: rtl/hand_scorer.sv
// Blackjack round sequencer: deals, player turn, dealer turn, and result.
module hand_scorer
  import hand_scorer_pkg::*;
#(
  parameter int DEALER_STAND = DEALER_STAND_DEF,
  parameter int TARGET       = TARGET_DEF
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       deal_i,
  input  logic       hit_i,
  input  logic       stand_i,
  input  logic       card_valid_i,
  input  logic [3:0] card_i,
  output logic       card_req_o,
  output logic       card_turn_o,
  output logic [4:0] player_total_o,
  output logic [4:0] dealer_total_o,
  output logic [2:0] phase_o,
  output logic [1:0] result_o
);

  localparam logic [4:0] STAND = 5'(DEALER_STAND);
  localparam logic [4:0] TGT   = 5'(TARGET);

  phase_e     state_q;
  result_e    result_q;
  logic       req_q, pend_q, turn_q;
  logic [4:0] p_total, d_total;
  logic       p_bust, d_bust;
  logic       card_ok, acc, clr;

  // Out-of-range card codes are dropped; the request simply stays pending.
  assign card_ok = (card_i != 4'd0) && (card_i <= 4'd10);
  assign acc     = pend_q && card_valid_i && card_ok;
  assign clr     = (state_q == PH_IDLE || state_q == PH_DONE) && deal_i;

  hand_accum #(.TARGET(TARGET)) u_player (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clr), .add_i(acc && !turn_q),
    .card_i(card_i), .total_o(p_total), .bust_o(p_bust)
  );

  hand_accum #(.TARGET(TARGET)) u_dealer (
    .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clr), .add_i(acc && turn_q),
    .card_i(card_i), .total_o(d_total), .bust_o(d_bust)
  );

  // Round FSM; card_req is a one-cycle strobe raised on the edge that opens a draw.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= PH_IDLE;
      result_q <= RES_NONE;
      req_q    <= 1'b0;
      pend_q   <= 1'b0;
      turn_q   <= 1'b0;
    end else begin
      req_q <= 1'b0;
      case (state_q)
        PH_IDLE, PH_DONE: if (deal_i) begin
          state_q  <= PH_DEAL_P1;
          result_q <= RES_NONE;
          req_q    <= 1'b1;
          pend_q   <= 1'b1;
          turn_q   <= 1'b0;
        end
        PH_DEAL_P1: if (acc) begin
          state_q <= PH_DEAL_D1;
          req_q   <= 1'b1;
          turn_q  <= 1'b1;
        end
        PH_DEAL_D1: if (acc) begin
          state_q <= PH_DEAL_P2;
          req_q   <= 1'b1;
          turn_q  <= 1'b0;
        end
        PH_DEAL_P2: if (acc) begin
          state_q <= PH_DEAL_D2;
          req_q   <= 1'b1;
          turn_q  <= 1'b1;
        end
        PH_DEAL_D2: if (acc) begin
          state_q <= PH_PLAYER;
          pend_q  <= 1'b0;
          turn_q  <= 1'b0;
        end
        // Totals are evaluated only with no draw outstanding, so they are current.
        PH_PLAYER: begin
          if (pend_q) begin
            if (acc) pend_q <= 1'b0;
          end else if (p_bust) begin
            state_q  <= PH_DONE;
            result_q <= RES_DEALER;
          end else if (p_total == TGT || stand_i) begin
            state_q <= PH_DEALER;
          end else if (hit_i) begin
            req_q  <= 1'b1;
            pend_q <= 1'b1;
            turn_q <= 1'b0;
          end
        end
        PH_DEALER: begin
          if (pend_q) begin
            if (acc) pend_q <= 1'b0;
          end else if (d_total < STAND) begin
            req_q  <= 1'b1;
            pend_q <= 1'b1;
            turn_q <= 1'b1;
          end else begin
            state_q  <= PH_DONE;
            result_q <= settle(p_total, d_total, d_bust);
          end
        end
      endcase
    end
  end

  assign card_req_o     = req_q;
  assign card_turn_o    = turn_q;
  assign player_total_o = p_total;
  assign dealer_total_o = d_total;
  assign phase_o        = state_q;
  assign result_o       = result_q;

endmodule

// File: tb/tb_hand_scorer.sv
// Scoreboard bench: each round's expected outcome is queued at deal time and a monitor
// compares it when the DUT enters DONE.
module tb_hand_scorer;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       deal = 1'b0, hit = 1'b0, stand = 1'b0, card_valid = 1'b0;
  logic [3:0] card = 4'd0;
  logic       card_req, card_turn;
  logic [4:0] ptot, dtot;
  logic [2:0] phase;
  logic [1:0] result;

  localparam logic [2:0] IDLE = 3'd0, DEAL_D1 = 3'd2, PLAYER = 3'd5, DONE = 3'd7;

  typedef struct { int pt; int dt; int res; int reqs; } exp_t;
  exp_t sb[$];
  int   deck[$];
  int   vectors = 0, miscompares = 0, req_cnt = 0, served = 0, didx = 0, junk_mode = 0;
  bit   srv_en = 1'b0;

  always #5 clk = ~clk;

  hand_scorer dut (
    .clk_i(clk), .rst_ni(rst_n), .deal_i(deal), .hit_i(hit), .stand_i(stand),
    .card_valid_i(card_valid), .card_i(card), .card_req_o(card_req), .card_turn_o(card_turn),
    .player_total_o(ptot), .dealer_total_o(dtot), .phase_o(phase), .result_o(result)
  );

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Best blackjack value of a hand: one ace may count 11 if that does not exceed 21.
  function automatic int best(input int h[$]);
    int s = 0;
    bit a = 1'b0;
    foreach (h[i]) begin
      s += h[i];
      if (h[i] == 1) a = 1'b1;
    end
    return (a && s + 10 <= 21) ? s + 10 : s;
  endfunction

  // Count every cycle card_req is seen high, so a stretched strobe shows up as extra pulses.
  always @(negedge clk) if (card_req) req_cnt++;

  // Card source: answers each request from the deck after a random delay, optionally junk first.
  initial begin : server
    int v;
    forever begin
      if (srv_en && card_req) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        if (junk_mode == 2 || (junk_mode == 1 && $urandom_range(0, 3) == 0)) begin
          v = $urandom_range(10, 15);
          if (v == 10) v = 0;
          card = 4'(v); card_valid = 1'b1;
          @(negedge clk);
          card_valid = 1'b0;
          repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        card = (didx < deck.size()) ? 4'(deck[didx]) : 4'd0;
        didx++;
        card_valid = 1'b1;
        @(negedge clk);
        card_valid = 1'b0;
        served++;
      end else begin
        @(negedge clk);
      end
    end
  end

  // Monitor: result must be 00 outside DONE; on each entry to DONE pop and compare.
  initial begin : monitor
    logic [2:0] prev;
    exp_t e;
    prev = IDLE;
    forever begin
      @(negedge clk);
      if (phase != DONE) chk("result_outside_done", int'(result), 0);
      if (phase == DONE && prev != DONE) begin
        if (sb.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL unexpected_done: DUT reached DONE with no round queued");
        end else begin
          e = sb.pop_front();
          chk("player_total", int'(ptot), e.pt);
          chk("dealer_total", int'(dtot), e.dt);
          chk("result", int'(result), e.res);
          chk("card_req_pulses", req_cnt, e.reqs);
        end
      end
      prev = phase;
    end
  end

  task automatic wait_served(input int n, output bit ok);
    int c = 0;
    while (served < n && c < 500) begin
      @(negedge clk);
      c++;
    end
    ok = (served >= n);
  endtask

  // Plays one round: player hits while below thr, then stands (with a simultaneous hit if hs).
  task automatic run_game(input int d[$], input int thr, input bit hs, input int jm);
    int   p[$], q[$];
    int   nx, k;
    bit   ok;
    exp_t e;
    p = '{d[0], d[2]};
    q = '{d[1], d[3]};
    nx = 4; k = 0;
    while (best(p) < thr && nx < d.size()) begin p.push_back(d[nx]); nx++; k++; end
    if (best(p) > 21) e.res = 2;
    else begin
      while (best(q) < 17 && nx < d.size()) begin q.push_back(d[nx]); nx++; end
      if (best(q) > 21 || best(p) > best(q)) e.res = 1;
      else if (best(q) > best(p))            e.res = 2;
      else                                   e.res = 3;
    end
    e.pt = best(p); e.dt = best(q); e.reqs = req_cnt + nx;
    sb.push_back(e);

    deck = d; didx = 0; served = 0; junk_mode = jm;
    deal = 1'b1; @(negedge clk); deal = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < k && ok; i++) begin
      wait_served(4 + i, ok);
      if (ok) begin hit = 1'b1; @(negedge clk); hit = 1'b0; end
    end
    if (ok) wait_served(4 + k, ok);
    if (ok) begin
      @(negedge clk);
      if (phase == PLAYER) begin
        stand = 1'b1; hit = hs;
        @(negedge clk);
        stand = 1'b0; hit = 1'b0;
      end
      for (int c = 0; c < 2000 && phase != DONE; c++) @(negedge clk);
      ok = (phase == DONE);
    end
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL round_timeout: phase %0d, expected %0d", phase, DONE);
      rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int d[$];
    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_phase", int'(phase), 0);
    chk("rst_card_req", int'(card_req), 0);
    chk("rst_card_turn", int'(card_turn), 0);
    chk("rst_player_total", int'(ptot), 0);
    chk("rst_dealer_total", int'(dtot), 0);
    chk("rst_result", int'(result), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of DEAL_D1 abandons the pending card.
    deal = 1'b1; @(negedge clk); deal = 1'b0;
    chk("deal_strobe", int'(card_req), 1);
    card = 4'd10; card_valid = 1'b1; @(negedge clk); card_valid = 1'b0;
    chk("phase_deal_d1", int'(phase), int'(DEAL_D1));
    chk("first_card_total", int'(ptot), 10);
    @(negedge clk);
    rst_n = 1'b0; #1;
    chk("midreset_phase", int'(phase), 0);
    chk("midreset_player_total", int'(ptot), 0);
    chk("midreset_card_req", int'(card_req), 0);
    @(negedge clk);
    rst_n = 1'b1;
    card = 4'd5; card_valid = 1'b1; @(negedge clk); card_valid = 1'b0;
    @(negedge clk);
    chk("late_card_player_total", int'(ptot), 0);
    chk("late_card_dealer_total", int'(dtot), 0);
    chk("late_card_phase", int'(phase), 0);
    chk("late_card_card_req", int'(card_req), 0);

    srv_en = 1'b1;
    // Soft 21 auto-stand; dealer 16 draws 5 -> push.
    run_game('{10, 7, 1, 9, 5}, 20, 1'b0, 0);
    // Player 15 hits 9 -> bust, 5 strobes.
    run_game('{10, 6, 5, 10, 9}, 20, 1'b0, 0);
    // Dealer soft 17 stands; player 18 wins.
    run_game('{10, 1, 8, 6}, 18, 1'b0, 0);
    // Hit and stand together: stand wins, no player card.
    run_game('{10, 9, 5, 8}, 12, 1'b1, 0);
    // Every request answered by an out-of-range code first.
    run_game('{4, 10, 3, 8, 9}, 13, 1'b0, 2);

    for (int g = 0; g < 40; g++) begin
      d.delete();
      for (int i = 0; i < 30; i++) d.push_back($urandom_range(1, 10));
      run_game(d, $urandom_range(12, 20), 1'($urandom_range(0, 1)), 1);
    end

    chk("scoreboard_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
